// File: rtl/axis_frame_replayer.sv
// AXI4-Stream frame source: replays a BRAM-resident image N_PASSES times with
// TUSER/TLAST framing, TREADY backpressure and idle gaps between passes.
module axis_frame_replayer #(
  parameter int DATA_W     = 32,
  parameter int PIXEL_W    = 24,
  parameter int IMG_W      = 640,
  parameter int IMG_H      = 480,
  parameter int N_PASSES   = 2,
  parameter int GAP_CYCLES = 2,
  localparam int ADDR_W    = (IMG_W * IMG_H > 1) ? $clog2(IMG_W * IMG_H) : 1
) (
  input  logic               ACLK,
  input  logic               ARESETn,
  input  logic               start,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic [7:0]         pass_idx,
  output logic               mem_en,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [PIXEL_W-1:0] mem_rdata,
  output logic [DATA_W-1:0]  M_AXIS_TDATA,
  output logic               M_AXIS_TVALID,
  output logic               M_AXIS_TLAST,
  output logic               M_AXIS_TUSER,
  input  logic               M_AXIS_TREADY
);

  localparam int NPIX  = IMG_W * IMG_H;
  localparam int CNT_W = $clog2(NPIX + 1);
  localparam int GAP_W = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [CNT_W-1:0] LAST_PIX  = CNT_W'(NPIX - 1);
  localparam logic [CNT_W-1:0] NPIX_C    = CNT_W'(NPIX);
  localparam logic [7:0]       LAST_PASS = 8'(N_PASSES - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'((GAP_CYCLES > 1) ? GAP_CYCLES - 2 : 0);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]         state;
  logic [GAP_W-1:0]   gap_cnt;
  logic [CNT_W-1:0]   rd_cnt;
  logic [7:0]         rd_pass;
  logic [CNT_W-1:0]   out_cnt;
  logic               inflight;
  logic [PIXEL_W-1:0] fifo_q [2];
  logic               wr_ptr;
  logic               rd_ptr;
  logic [1:0]         fifo_cnt;

  logic               tvalid;
  logic               hs;
  logic               last_beat;
  logic               final_pass;
  logic               push;
  logic               pop;
  logic [PIXEL_W-1:0] head;

  // An empty FIFO forwards the returning read directly so the first beat
  // appears two cycles after start; a stalled bypass beat is captured into
  // the FIFO and re-presented unchanged from there.
  always_comb begin
    tvalid     = (fifo_cnt != 2'd0) || inflight;
    hs         = tvalid && M_AXIS_TREADY;
    last_beat  = (out_cnt == LAST_PIX);
    final_pass = (pass_idx == LAST_PASS);
    push       = inflight && !((fifo_cnt == 2'd0) && hs);
    pop        = hs && (fifo_cnt != 2'd0);
    head       = (fifo_cnt != 2'd0) ? fifo_q[rd_ptr] : mem_rdata;
    mem_en     = (state == S_RUN) && (rd_cnt != NPIX_C)
                 && (({1'b0, fifo_cnt} + {2'b00, inflight}) < 3'd2);
    mem_addr   = rd_cnt[ADDR_W-1:0];
  end

  assign M_AXIS_TVALID = tvalid;
  assign M_AXIS_TDATA  = tvalid ? DATA_W'(head) : '0;
  assign M_AXIS_TUSER  = tvalid && (out_cnt == '0);
  assign M_AXIS_TLAST  = tvalid && last_beat;
  assign busy          = (state == S_RUN) || (state == S_GAP);
  assign done          = (state == S_DONE);

  always_ff @(posedge ACLK) begin
    if (push) fifo_q[wr_ptr] <= mem_rdata;
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn || abort) begin
      state    <= S_IDLE;
      gap_cnt  <= '0;
      rd_cnt   <= '0;
      rd_pass  <= '0;
      out_cnt  <= '0;
      pass_idx <= '0;
      inflight <= 1'b0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      fifo_cnt <= '0;
    end else begin
      inflight <= mem_en;
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase

      // Without a gap the read side runs ahead into the next pass so passes
      // stream back to back; with a gap it restarts on the TLAST handshake.
      if ((state == S_IDLE) && start) begin
        rd_cnt  <= '0;
        rd_pass <= '0;
      end else if (mem_en) begin
        if ((GAP_CYCLES == 0) && (rd_cnt == LAST_PIX) && (rd_pass != LAST_PASS)) begin
          rd_cnt  <= '0;
          rd_pass <= rd_pass + 8'd1;
        end else begin
          rd_cnt <= rd_cnt + 1'b1;
        end
      end else if (hs && last_beat && !final_pass && (GAP_CYCLES != 0)) begin
        rd_cnt <= '0;
      end

      if (hs) begin
        out_cnt <= last_beat ? '0 : out_cnt + 1'b1;
        if (last_beat) pass_idx <= final_pass ? 8'd0 : pass_idx + 8'd1;
      end

      // The first RUN cycle after a gap only issues the read, so the GAP state
      // itself lasts one cycle less than the visible idle window.
      case (state)
        S_IDLE: if (start) state <= S_RUN;
        S_RUN: begin
          if (hs && last_beat) begin
            if (final_pass) begin
              state <= S_DONE;
            end else if (GAP_CYCLES > 1) begin
              state   <= S_GAP;
              gap_cnt <= GAP_LOAD;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == '0) state <= S_RUN;
          else               gap_cnt <= gap_cnt - 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
